// File: rtl/pic_priority_resolver_pkg.sv
// Shared PIC definitions: acknowledge FSM states, level width and the
// rotating-priority rank helper used by the resolver and the control logic.
package pic_pkg;

    localparam int PIC_LVL_W = 3;
    localparam logic [PIC_LVL_W-1:0] SPURIOUS_LVL = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        ACK1,
        ACK2,
        DONE
    } ack_st_t;

    // 0 is the highest rank; 3-bit arithmetic supplies the mod-8 wrap.
    function automatic logic [PIC_LVL_W-1:0] prio_rank(
        input logic [PIC_LVL_W-1:0] lvl,
        input logic [PIC_LVL_W-1:0] lowest
    );
        return lvl - lowest - 3'd1;
    endfunction

endpackage

// File: rtl/pic_priority_resolver_if.sv
// Request/acknowledge/command bus between the control logic (master) and the
// priority resolver (slave).
interface pic_priority_resolver_if;
    import pic_pkg::*;

    logic [7:0]           ir;
    logic                 ltim;
    logic [7:0]           mask;
    logic                 inta_n;
    logic                 aeoi;
    logic                 rotate;
    logic                 eoi_stb;
    logic                 eoi_spec;
    logic [PIC_LVL_W-1:0] eoi_lvl;
    logic                 setpri_stb;
    logic [7:0]           irr;
    logic [7:0]           isr;
    logic                 isprior;
    logic [PIC_LVL_W-1:0] vec_lvl;
    logic                 vec_valid;
    logic                 spurious;

    modport master (
        output ir, ltim, mask, inta_n, aeoi, rotate,
               eoi_stb, eoi_spec, eoi_lvl, setpri_stb,
        input  irr, isr, isprior, vec_lvl, vec_valid, spurious
    );

    modport slave (
        input  ir, ltim, mask, inta_n, aeoi, rotate,
               eoi_stb, eoi_spec, eoi_lvl, setpri_stb,
        output irr, isr, isprior, vec_lvl, vec_valid, spurious
    );

endinterface

// File: rtl/pic_priority_resolver_prio_encode.sv
// Rotating-priority scanner: returns the first set bit of vec, scanning from
// level lowest+1 upward with wrap.
module pic_prio_encode
    import pic_pkg::*;
(
    input  logic [7:0]           vec,
    input  logic [PIC_LVL_W-1:0] lowest,
    output logic                 found,
    output logic [PIC_LVL_W-1:0] lvl
);

    logic [PIC_LVL_W-1:0] idx;

    always_comb begin
        found = 1'b0;
        lvl   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = lowest + PIC_LVL_W'(i) + 3'd1;
            if (!found && vec[idx]) begin
                found = 1'b1;
                lvl   = idx;
            end
        end
    end

endmodule

// File: rtl/pic_priority_resolver.sv
// PIC interrupt-request front end: IR capture into IRR, masking, fully nested
// priority resolution against ISR, INTA sequencing, EOI and set-priority.
module pic_priority_resolver
    import pic_pkg::*;
#(
    parameter int NUM_IR      = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    pic_priority_resolver_if.slave bus
);

    logic [NUM_IR-1:0]      ir_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] inta_sync;
    logic [NUM_IR-1:0]      ir_s, ir_d, ir_rise;
    logic                   ack_s, ack_d, ack_fall, ack_rise;

    logic [NUM_IR-1:0]      irr_q, irr_d, isr_q, isr_d, cand;
    logic [NUM_IR-1:0]      isr_set, ack_clr, eoi_clr;
    logic                   isprior_q, isprior_d;
    logic [PIC_LVL_W-1:0]   lowest_q, lowest_d;
    logic [PIC_LVL_W-1:0]   vec_lvl_q, vec_lvl_d;
    logic                   vec_valid_q, vec_valid_d;
    logic                   spurious_q, spurious_d;
    logic                   win_found, isp_found;
    logic [PIC_LVL_W-1:0]   win_lvl, isp_lvl;
    logic                   ack_rot, eoi_rot;
    logic [PIC_LVL_W-1:0]   eoi_rot_lvl;
    ack_st_t                state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) ir_sync[i] <= '0;
            inta_sync <= '0;
            ir_d      <= '0;
            ack_d     <= 1'b0;
        end else begin
            ir_sync[0] <= bus.ir;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) ir_sync[i] <= ir_sync[i-1];
            inta_sync <= {inta_sync[SYNC_STAGES-2:0], bus.inta_n};
            ir_d      <= ir_s;
            ack_d     <= ack_s;
        end
    end

    assign ir_s     = ir_sync[SYNC_STAGES-1];
    assign ack_s    = inta_sync[SYNC_STAGES-1];
    assign ir_rise  = ir_s & ~ir_d;
    assign ack_fall = ack_d & ~ack_s;
    assign ack_rise = ~ack_d & ack_s;

    assign cand = irr_q & ~bus.mask;

    pic_prio_encode u_win (
        .vec    (cand),
        .lowest (lowest_q),
        .found  (win_found),
        .lvl    (win_lvl)
    );

    pic_prio_encode u_isp (
        .vec    (isr_q),
        .lowest (lowest_q),
        .found  (isp_found),
        .lvl    (isp_lvl)
    );

    assign isprior_d = win_found &&
        (!isp_found || (prio_rank(win_lvl, lowest_q) < prio_rank(isp_lvl, lowest_q)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        vec_lvl_d   = vec_lvl_q;
        vec_valid_d = vec_valid_q;
        spurious_d  = spurious_q;
        isr_set     = '0;
        ack_clr     = '0;
        ack_rot     = 1'b0;
        case (state_q)
            IDLE: if (ack_fall) begin
                state_d     = ACK1;
                vec_valid_d = 1'b1;
                if (win_found) begin
                    vec_lvl_d        = win_lvl;
                    spurious_d       = 1'b0;
                    isr_set[win_lvl] = 1'b1;
                end else begin
                    vec_lvl_d  = SPURIOUS_LVL;
                    spurious_d = 1'b1;
                end
            end
            ACK1: if (ack_rise) state_d = ACK2;
            ACK2: if (ack_fall) state_d = DONE;
            DONE: if (ack_rise) begin
                state_d     = IDLE;
                vec_valid_d = 1'b0;
                spurious_d  = 1'b0;
                if (bus.aeoi && !spurious_q) begin
                    ack_clr[vec_lvl_q] = 1'b1;
                    ack_rot            = bus.rotate;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A specific EOI on an idle level clears nothing and therefore never rotates.
    always_comb begin
        eoi_clr     = '0;
        eoi_rot     = 1'b0;
        eoi_rot_lvl = '0;
        if (bus.eoi_stb) begin
            if (bus.eoi_spec) begin
                if (isr_q[bus.eoi_lvl]) begin
                    eoi_clr[bus.eoi_lvl] = 1'b1;
                    eoi_rot              = bus.rotate;
                    eoi_rot_lvl          = bus.eoi_lvl;
                end
            end else if (isp_found) begin
                eoi_clr[isp_lvl] = 1'b1;
                eoi_rot          = bus.rotate;
                eoi_rot_lvl      = isp_lvl;
            end
        end
    end

    always_comb begin
        isr_d = (isr_q & ~(eoi_clr | ack_clr)) | isr_set;
        irr_d = bus.ltim ? ir_s : ((irr_q & ~isr_set) | ir_rise);
        lowest_d = lowest_q;
        if (ack_rot)        lowest_d = vec_lvl_q;
        if (eoi_rot)        lowest_d = eoi_rot_lvl;
        if (bus.setpri_stb) lowest_d = bus.eoi_lvl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irr_q       <= '0;
            isr_q       <= '0;
            isprior_q   <= 1'b0;
            lowest_q    <= 3'd7;
            vec_lvl_q   <= '0;
            vec_valid_q <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            isprior_q   <= isprior_d;
            lowest_q    <= lowest_d;
            vec_lvl_q   <= vec_lvl_d;
            vec_valid_q <= vec_valid_d;
            spurious_q  <= spurious_d;
        end
    end

    assign bus.irr       = irr_q;
    assign bus.isr       = isr_q;
    assign bus.isprior   = isprior_q;
    assign bus.vec_lvl   = vec_lvl_q;
    assign bus.vec_valid = vec_valid_q;
    assign bus.spurious  = spurious_q;

endmodule

// File: tb/tb_pic_priority_resolver.sv
// Randomized and directed bench for pic_priority_resolver with a transaction-
// level PIC model and a scoreboard on the acknowledge vector.
module tb_pic_priority_resolver;

    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst_n;

    pic_priority_resolver_if bus();

    pic_priority_resolver #(.NUM_IR(8), .SYNC_STAGES(SYNC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int lvl;
        int spur;
    } exp_t;
    exp_t sb[$];

    bit [7:0] m_irr, m_isr;
    int m_low, m_phase, m_vlvl, m_vspur;

    function automatic int rank(input int lvl, input int low);
        return (lvl - low + 15) % 8;
    endfunction

    function automatic int top_lvl(input bit [7:0] v, input int low);
        int best = -1;
        for (int i = 0; i < 8; i++)
            if (v[i] && (best < 0 || rank(i, low) < rank(best, low))) best = i;
        return best;
    endfunction

    function automatic int model_isprior();
        int c = top_lvl(m_irr & ~bus.mask, m_low);
        int p = top_lvl(m_isr, m_low);
        return (c >= 0 && (p < 0 || rank(c, m_low) < rank(p, m_low))) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_irr"}, bus.irr, m_irr);
        chk({tag, "_isr"}, bus.isr, m_isr);
        chk({tag, "_isprior"}, bus.isprior, model_isprior());
    endtask

    task automatic model_reset();
        m_irr = '0; m_isr = '0; m_low = 7; m_phase = 0; m_vlvl = 0; m_vspur = 0;
    endtask

    task automatic do_reset();
        bus.ir = '0; bus.mask = '0; bus.ltim = 1'b0; bus.aeoi = 1'b0; bus.rotate = 1'b0;
        bus.eoi_stb = 1'b0; bus.setpri_stb = 1'b0; bus.inta_n = 1'b1;
        rst_n = 1'b0;
        model_reset();
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
    endtask

    task automatic pulse_ir(input bit [7:0] bits);
        bus.ir = bits;
        cyc(SYNC + 3);
        if (!bus.ltim) m_irr |= bits;
        bus.ir = '0;
        cyc(SYNC + 3);
    endtask

    task automatic inta_fall();
        int w;
        bus.inta_n = 1'b0;
        if (m_phase == 0) begin
            w = top_lvl(m_irr & ~bus.mask, m_low);
            if (w >= 0) begin
                m_vlvl = w; m_vspur = 0;
                m_isr[w] = 1'b1;
                if (!bus.ltim) m_irr[w] = 1'b0;
            end else begin
                m_vlvl = 7; m_vspur = 1;
            end
            sb.push_back('{lvl: m_vlvl, spur: m_vspur});
            m_phase = 1;
        end else if (m_phase == 2) begin
            m_phase = 3;
        end
        cyc(6);
    endtask

    task automatic inta_rise();
        bus.inta_n = 1'b1;
        if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 3) begin
            m_phase = 0;
            if (bus.aeoi && m_vspur == 0) begin
                m_isr[m_vlvl] = 1'b0;
                if (bus.rotate) m_low = m_vlvl;
            end
        end
        cyc(6);
    endtask

    task automatic inta_pair();
        inta_fall(); inta_rise(); inta_fall(); inta_rise();
    endtask

    task automatic eoi_cmd(input bit spec, input int lvl);
        int cl = -1;
        bus.eoi_spec = spec;
        bus.eoi_lvl  = 3'(lvl);
        bus.eoi_stb  = 1'b1;
        if (spec) begin
            if (m_isr[lvl]) cl = lvl;
        end else begin
            cl = top_lvl(m_isr, m_low);
        end
        if (cl >= 0) begin
            m_isr[cl] = 1'b0;
            if (bus.rotate) m_low = cl;
        end
        cyc(1);
        bus.eoi_stb = 1'b0;
        cyc(2);
    endtask

    task automatic setpri(input int lvl);
        bus.eoi_lvl    = 3'(lvl);
        bus.setpri_stb = 1'b1;
        m_low = lvl;
        cyc(1);
        bus.setpri_stb = 1'b0;
        cyc(2);
    endtask

    // Scoreboard monitor: one expected vector per first-INTA, popped when the
    // DUT raises vec_valid.
    initial begin
        bit vv_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.vec_valid && !vv_prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got vec_lvl %0d with no expected entry", bus.vec_lvl);
                end else begin
                    e = sb.pop_front();
                    chk("sb_vec_lvl", bus.vec_lvl, e.lvl);
                    chk("sb_spurious", bus.spurious, e.spur);
                end
            end
            if (!bus.vec_valid && vv_prev) chk("sb_spur_clear", bus.spurious, 0);
            vv_prev = bus.vec_valid;
        end
    end

    initial begin
        bit [7:0] bits;
        bus.ir = '0; bus.mask = '0; bus.ltim = 1'b0; bus.aeoi = 1'b0; bus.rotate = 1'b0;
        bus.eoi_stb = 1'b0; bus.eoi_spec = 1'b0; bus.eoi_lvl = '0; bus.setpri_stb = 1'b0;
        bus.inta_n = 1'b1;
        rst_n = 1'b0;
        model_reset();
        cyc(2);
        chk("rst_irr", bus.irr, 0);
        chk("rst_isr", bus.isr, 0);
        chk("rst_vec_valid", bus.vec_valid, 0);
        chk("rst_spurious", bus.spurious, 0);
        chk("rst_isprior", bus.isprior, 0);
        rst_n = 1'b1;
        cyc(3);

        // 1: edge capture, first INTA, non-specific EOI
        pulse_ir(8'h28);
        chk("t1_irr", bus.irr, 'h28);
        chk("t1_isprior", bus.isprior, 1);
        inta_fall();
        chk("t1_vec_lvl", bus.vec_lvl, 3);
        chk("t1_isr", bus.isr, 'h08);
        chk("t1_irr_after", bus.irr, 'h20);
        inta_rise(); inta_fall(); inta_rise();
        eoi_cmd(1'b0, 0);
        chk("t1_isr_eoi", bus.isr, 0);
        check_status("t1");

        // 2: fully nested priority and mask latency
        do_reset();
        pulse_ir(8'h04);
        inta_pair();
        pulse_ir(8'h10);
        chk("t2_isprior_lower", bus.isprior, 0);
        pulse_ir(8'h02);
        chk("t2_isprior_higher", bus.isprior, 1);
        bus.mask = 8'h02;
        #1 chk("t2_isprior_before_edge", bus.isprior, 1);
        cyc(1);
        chk("t2_isprior_masked", bus.isprior, 0);
        check_status("t2");

        // 3: AEOI with rotation
        do_reset();
        bus.aeoi = 1'b1; bus.rotate = 1'b1;
        pulse_ir(8'h04);
        inta_pair();
        chk("t3_isr_aeoi", bus.isr, 0);
        pulse_ir(8'h09);
        inta_fall();
        chk("t3_vec_rotated", bus.vec_lvl, 3);
        inta_rise(); inta_fall(); inta_rise();
        check_status("t3");
        bus.aeoi = 1'b0; bus.rotate = 1'b0;

        // 4: spurious acknowledge
        do_reset();
        pulse_ir(8'h04);
        inta_pair();
        inta_fall();
        chk("t4_vec_lvl", bus.vec_lvl, 7);
        chk("t4_spurious", bus.spurious, 1);
        chk("t4_isr", bus.isr, 'h04);
        inta_rise(); inta_fall(); inta_rise();
        chk("t4_spur_clear", bus.spurious, 0);
        chk("t4_valid_clear", bus.vec_valid, 0);

        // 5: level-triggered capture
        do_reset();
        bus.ltim = 1'b1;
        bus.ir = 8'h40;
        cyc(SYNC + 3);
        m_irr = 8'h40;
        chk("t5_irr", bus.irr, 'h40);
        inta_fall();
        chk("t5_vec_lvl", bus.vec_lvl, 6);
        chk("t5_irr_kept", bus.irr, 'h40);
        inta_rise(); inta_fall(); inta_rise();
        bus.ir = '0;
        m_irr = '0;
        cyc(SYNC);
        chk("t5_irr_hold", bus.irr, 'h40);
        cyc(1);
        chk("t5_irr_drop", bus.irr, 0);
        eoi_cmd(1'b0, 0);
        bus.ltim = 1'b0;
        check_status("t5");

        // 6: reset in the middle of an acknowledge
        do_reset();
        pulse_ir(8'h10);
        inta_fall();
        chk("t6_isr_ack1", bus.isr, 'h10);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_irr", bus.irr, 0);
        chk("t6_rst_isr", bus.isr, 0);
        chk("t6_rst_vec_lvl", bus.vec_lvl, 0);
        chk("t6_rst_vec_valid", bus.vec_valid, 0);
        chk("t6_rst_spurious", bus.spurious, 0);
        chk("t6_rst_isprior", bus.isprior, 0);
        model_reset();
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        inta_rise();
        inta_fall();
        chk("t6_isr_trailing", bus.isr, 0);
        inta_rise(); inta_fall(); inta_rise();
        check_status("t6");

        // Randomized traffic against the model
        do_reset();
        for (int it = 0; it < 40; it++) begin
            bus.mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            bits = 8'($urandom) & 8'($urandom);
            pulse_ir(bits);
            check_status("rnd_req");
            bus.aeoi   = 1'($urandom_range(0, 1));
            bus.rotate = 1'($urandom_range(0, 1));
            inta_pair();
            check_status("rnd_ack");
            if ($urandom_range(0, 1) == 1) eoi_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
            if ($urandom_range(0, 4) == 0) setpri(int'($urandom_range(0, 7)));
            cyc(2);
            check_status("rnd_cmd");
        end

        cyc(5);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
